kbd_event_sched: RTL and testbench



---
 rtl/kbd_sched_pkg.sv | 22 ++
 rtl/kbd_evt_fifo.sv | 91 +++++++++
 rtl/kbd_event_sched.sv | 171 +++++++++++++++++
 tb/tb_kbd_event_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_sched_pkg.sv
// kbd_sched_pkg
// Shared types and constants for the keyboard event scheduler.
//   kbd_evt_t      : one queued key event {press, code[8:0]}
//   sched_state_e  : issue FSM states
//   KEY_TOGGLE_BIT : position of the toggle strobe in the 11-bit key word
package kbd_sched_pkg;

    typedef struct packed {
        logic       press;
        logic [8:0] code;
    } kbd_evt_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_e;

    localparam int KEY_TOGGLE_BIT = 10;

endpackage

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo
// Synchronous first-in first-out queue of key events. The head entry is
// presented combinationally so the consumer can pop it and use it on the same
// edge. A push while full is ignored; the owner decides what that means.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   ce_i          : clock enable; pointers and level move only when high
//   flush_i       : empty the queue (wins over push/pop in the same cycle)
//   push_i/push_data_i : write request and data
//   pop_i/pop_data_o   : read request and head entry
//   full_o, empty_o, level_o : occupancy status
module kbd_evt_fifo
    import kbd_sched_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [9:0]    push_data_i,
    input  logic          pop_i,
    output logic [9:0]    pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    kbd_evt_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full_o     = (level_q == FULL_LEVEL);
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_push = ce_i & ~flush_i & push_i & ~full_o;
    assign do_pop  = ce_i & ~flush_i & pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (ce_i && flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && do_push) begin
            mem_q[wr_ptr_q] <= kbd_evt_t'(push_data_i);
        end
    end

endmodule

// File: rtl/kbd_event_sched.sv
// kbd_event_sched
// Merges live PS/2 key events and injected key events into one ordered queue
// and hands them one at a time to the Mac keyboard responder using the
// toggle-strobe key format. After each issue it waits for the responder to
// take the key (pending high, then low) or for an acknowledge timeout, then
// enforces a quiet gap before the next issue.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   ce             : clock enable for all non-reset state
//   flush          : discard queued events and restart the gap
//   ps2_key        : {strobe, press, code}; each strobe change is one event
//   inj_valid/inj_key/inj_ready : injector handshake, {press, code}
//   kbd_pending    : responder holds an unconsumed key
//   kbd_key        : key word to the responder, strobe toggles per issue
//   overflow       : sticky, a PS/2 event was dropped on a full queue
//   fifo_level     : current queue occupancy
module kbd_event_sched
    import kbd_sched_pkg::*;
#(
    parameter int  DEPTH       = 8,
    parameter int  INJ_RESERVE = 2,
    parameter int  GAP_CYCLES  = 16,
    parameter int  ACK_TIMEOUT = 64,
    localparam int LW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          flush,
    input  logic [10:0]   ps2_key,
    input  logic          inj_valid,
    input  logic [9:0]    inj_key,
    output logic          inj_ready,
    input  logic          kbd_pending,
    output logic [10:0]   kbd_key,
    output logic          overflow,
    output logic [LW-1:0] fifo_level
);

    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    // free > INJ_RESERVE is the same as level < DEPTH - INJ_RESERVE
    localparam logic [LW-1:0]    INJ_LIMIT = LW'(DEPTH - INJ_RESERVE);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      kbd_key_q, kbd_key_d;
    logic             overflow_q, overflow_d;
    logic             old_stb_q;

    logic             ps2_evt;
    logic             inj_push;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    kbd_evt_t         push_evt;
    kbd_evt_t         head_evt;

    // ------------------------------------------------------------------
    // Source arbitration: PS/2 has strict priority, so the injector is
    // simply not offered a slot in any cycle that carries a PS/2 event.
    // ------------------------------------------------------------------
    assign ps2_evt   = ce & (ps2_key[KEY_TOGGLE_BIT] != old_stb_q);
    assign inj_ready = reset_n & ~flush & ~ps2_evt & (fifo_level < INJ_LIMIT);
    assign inj_push  = inj_valid & inj_ready & ce;
    assign fifo_push = ps2_evt | inj_push;
    assign push_evt  = ps2_evt ? kbd_evt_t'(ps2_key[9:0]) : kbd_evt_t'(inj_key);

    // A PS/2 event meeting a full queue is lost; flag it for software.
    assign overflow_d = overflow_q | (ps2_evt & fifo_full & ~flush);

    kbd_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_i        (ce),
        .flush_i     (flush),
        .push_i      (fifo_push),
        .push_data_i (push_evt),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_evt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // ------------------------------------------------------------------
    // Issue FSM. One counter serves both the acknowledge timeout and the
    // inter-event gap; it is cleared on every entry to WAIT_ACK and GAP.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kbd_key_d = kbd_key_q;
        fifo_pop  = 1'b0;
        if (ce) begin
            if (flush) begin
                state_d = GAP;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!fifo_empty && !kbd_pending) begin
                            fifo_pop  = 1'b1;
                            kbd_key_d = {~kbd_key_q[KEY_TOGGLE_BIT], head_evt};
                            cnt_d     = '0;
                            state_d   = WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        // Timeout covers events the responder silently
                        // swallows and therefore never flags as pending.
                        if (kbd_pending) begin
                            state_d = WAIT_DONE;
                        end else if (cnt_q == ACK_LAST) begin
                            state_d = GAP;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    WAIT_DONE: begin
                        // No timeout: a slow host poll or a multi-byte
                        // keypad sequence legitimately holds pending high.
                        if (!kbd_pending) begin
                            state_d = GAP;
                            cnt_d   = '0;
                        end
                    end
                    GAP: begin
                        if (cnt_q == GAP_LAST) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // The strobe history is loaded even in reset so that whatever level the
    // PS/2 side holds at release is not mistaken for a new event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            kbd_key_q  <= '0;
            overflow_q <= 1'b0;
            old_stb_q  <= ps2_key[KEY_TOGGLE_BIT];
        end else if (ce) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kbd_key_q  <= kbd_key_d;
            overflow_q <= overflow_d;
            old_stb_q  <= ps2_key[KEY_TOGGLE_BIT];
        end
    end

    assign kbd_key  = kbd_key_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_kbd_event_sched.sv
// tb_kbd_event_sched
// Directed bench for kbd_event_sched. Expected key events are queued as the
// stimulus is driven and compared in order whenever kbd_key[10] toggles.
module tb_kbd_event_sched;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        flush;
    logic [10:0] ps2_key;
    logic        inj_valid;
    logic [9:0]  inj_key;
    logic        inj_ready;
    logic        kbd_pending;
    logic [10:0] kbd_key;
    logic        overflow;
    logic [3:0]  fifo_level;

    always #5 clk = ~clk;

    kbd_event_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .flush       (flush),
        .ps2_key     (ps2_key),
        .inj_valid   (inj_valid),
        .inj_key     (inj_key),
        .inj_ready   (inj_ready),
        .kbd_pending (kbd_pending),
        .kbd_key     (kbd_key),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         issue_cnt = 0;
    int         issue_cyc = 0;
    logic       tog_q = 1'b0;
    logic       mon_en = 1'b0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; any strobe toggle on kbd_key is matched against the scoreboard.
    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en && (kbd_key[10] !== tog_q)) begin
            tog_q = kbd_key[10];
            issue_cnt++;
            issue_cyc = cyc;
            check("issue_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("issue_key", 32'(kbd_key[9:0]), 32'(e));
                $display("issue cyc=%0d key=%03h expected=%03h", cyc, kbd_key[9:0], e);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ps2_send(input logic press, input logic [8:0] code);
        ps2_key = {~ps2_key[10], press, code};
        if (exp_q.size() < DEPTH) exp_q.push_back({press, code});
        tick();
    endtask

    task automatic wait_issue(input int max_cyc, input string tag);
        int start;
        int n;
        start = issue_cnt;
        n = 0;
        while (issue_cnt == start && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(issue_cnt != start), 32'd1);
    endtask

    // Responder consumes the key: pending high two cycles, then low (-> GAP).
    task automatic ack();
        kbd_pending = 1'b1;
        ticks(2);
        kbd_pending = 1'b0;
        tick();
    endtask

    initial begin
        int t0;
        int end_cyc;
        logic [10:0] kk;

        reset_n = 1'b0; ce = 1'b1; flush = 1'b0; ps2_key = '0;
        inj_valid = 1'b0; inj_key = '0; kbd_pending = 1'b0;
        ticks(3);
        check("rst_kbd_key", 32'(kbd_key), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_inj_ready", 32'(inj_ready), 32'd0);
        reset_n = 1'b1;
        tog_q = 1'b0;
        mon_en = 1'b1;
        ticks(2);
        check("idle_no_issue", 32'(issue_cnt), 32'd0);

        // 1. single press, two-edge latency, gap before next issue
        ps2_send(1'b1, 9'h01C);
        check("t1_level_e1", 32'(fifo_level), 32'd1);
        check("t1_key_e1", 32'(kbd_key), 32'd0);
        tick();
        check("t1_key_e2", 32'(kbd_key), 32'h61C);
        check("t1_issued", 32'(issue_cnt), 32'd1);
        kbd_pending = 1'b1;
        ticks(5);
        kbd_pending = 1'b0;
        tick();
        end_cyc = cyc;
        ps2_send(1'b1, 9'h01D);
        wait_issue(40, "t1_second_issue");
        check("t1_gap_min", 32'((issue_cyc - end_cyc) >= 16), 32'd1);
        check("t1_gap_max", 32'((issue_cyc - end_cyc) <= 17), 32'd1);
        ack();

        // 2. overflow with responder busy
        kbd_pending = 1'b1;
        ticks(20);
        for (int i = 1; i <= 10; i++) ps2_send(1'b0, 9'(i));
        check("t2_level_full", 32'(fifo_level), 32'd8);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_model_level", 32'(exp_q.size()), 32'd8);
        kbd_pending = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_issue(40, "t2_drain_issue");
            ack();
        end
        check("t2_drained", 32'(fifo_level), 32'd0);

        // 3. simultaneous PS/2 and injector
        kbd_pending = 1'b1;
        inj_key = 10'h11C;
        inj_valid = 1'b1;
        ps2_key = {~ps2_key[10], 1'b0, 9'h015};
        exp_q.push_back(10'h015);
        #1;
        check("t3_inj_stall", 32'(inj_ready), 32'd0);
        tick();
        check("t3_inj_ready", 32'(inj_ready), 32'd1);
        exp_q.push_back(10'h11C);
        tick();
        inj_valid = 1'b0;
        check("t3_level", 32'(fifo_level), 32'd2);
        kbd_pending = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_issue(40, "t3_issue");
            ack();
        end

        // 4. injector reserve
        kbd_pending = 1'b1;
        for (int i = 0; i < 6; i++) begin
            inj_key = {1'b0, 9'(9'h030 + i)};
            inj_valid = 1'b1;
            #1;
            check("t4_inj_ready_fill", 32'(inj_ready), 32'(exp_q.size() < 6));
            exp_q.push_back(inj_key);
            tick();
        end
        inj_key = 10'h03F;
        #1;
        check("t4_inj_refused", 32'(inj_ready), 32'd0);
        tick();
        check("t4_level6", 32'(fifo_level), 32'd6);
        ps2_send(1'b1, 9'h040);
        check("t4_level7", 32'(fifo_level), 32'd7);
        check("t4_inj_still_refused", 32'(inj_ready), 32'd0);
        inj_valid = 1'b0;
        kbd_pending = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wait_issue(40, "t4_issue");
            ack();
        end

        // 5. acknowledge timeout
        kbd_pending = 1'b1;
        ps2_send(1'b0, 9'h058);
        ps2_send(1'b0, 9'h05A);
        ticks(20);
        kbd_pending = 1'b0;
        wait_issue(5, "t5_first_issue");
        t0 = issue_cyc;
        wait_issue(120, "t5_after_timeout");
        check("t5_timeout_min", 32'((issue_cyc - t0) >= 80), 32'd1);
        check("t5_timeout_max", 32'((issue_cyc - t0) <= 81), 32'd1);
        ack();

        // 6a. flush in WAIT_DONE with three queued entries
        ticks(20);
        ps2_send(1'b1, 9'h0AA);
        wait_issue(5, "t6_a_issue");
        kbd_pending = 1'b1;
        tick();
        ps2_send(1'b1, 9'h0B1);
        ps2_send(1'b1, 9'h0B2);
        ps2_send(1'b1, 9'h0B3);
        check("t6_level3", 32'(fifo_level), 32'd3);
        kk = kbd_key;
        flush = 1'b1;
        tick();
        end_cyc = cyc;
        flush = 1'b0;
        exp_q.delete();
        check("t6_flush_level", 32'(fifo_level), 32'd0);
        check("t6_flush_key", 32'(kbd_key), 32'(kk));
        kbd_pending = 1'b0;
        ps2_send(1'b0, 9'h0C0);
        wait_issue(40, "t6_post_flush_issue");
        check("t6_gap_min", 32'((issue_cyc - end_cyc) >= 16), 32'd1);
        check("t6_gap_max", 32'((issue_cyc - end_cyc) <= 17), 32'd1);
        ack();

        // 6b. reset in WAIT_ACK with ce low
        kbd_pending = 1'b1;
        ticks(20);
        ps2_send(1'b0, 9'h0C1);
        ps2_send(1'b0, 9'h0C2);
        kbd_pending = 1'b0;
        wait_issue(5, "t6_c_issue");
        check("t6_overflow_sticky", 32'(overflow), 32'd1);
        check("t6_pre_reset_level", 32'(fifo_level), 32'd1);
        mon_en = 1'b0;
        ce = 1'b0;
        reset_n = 1'b0;
        ps2_key[10] = 1'b1;
        tick();
        check("t6_rst_kbd_key", 32'(kbd_key), 32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        check("t6_rst_inj_ready", 32'(inj_ready), 32'd0);
        reset_n = 1'b1;
        ce = 1'b1;
        exp_q.delete();
        tog_q = kbd_key[10];
        mon_en = 1'b1;
        ticks(5);
        check("t6_no_spurious_level", 32'(fifo_level), 32'd0);
        check("t6_no_spurious_key", 32'(kbd_key), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
